// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and sizing helper for the mem_arbiter slice.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 4;

  function automatic int unsigned wait_w(input int unsigned max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the inst/data requesters, the arbiter and the unified SRAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied fetch cycles; prio_i hands fetch the next slot once
// the count saturates at MAX_WAIT.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  output logic prio_i
);

  localparam int unsigned         WAIT_W  = wait_w(MAX_WAIT);
  localparam logic [WAIT_W-1:0]   CNT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || i_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CNT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign prio_i = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data port.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("mem_arbiter: MAX_WAIT out of range 1..15");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("mem_arbiter: DATA_W must be a multiple of 8");
  end

  logic              prio_i;
  logic              i_win;
  logic              d_win;
  logic              mem_en_sel;
  logic              mem_we_sel;
  logic [STRB_W-1:0] mem_wstrb_sel;
  logic [ADDR_W-1:0] mem_addr_sel;
  logic [DATA_W-1:0] mem_wdata_sel;
  owner_t            owner_q;
  owner_t            owner_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_req  (bus.i_req),
    .i_gnt  (i_win),
    .prio_i (prio_i)
  );
`else
  assign prio_i = 1'b0;
`endif

  // Grants are masked during reset so the SRAM sees no access while rst is high.
  always_comb begin
    i_win = !rst && bus.i_req && (!bus.d_req || prio_i);
    d_win = !rst && bus.d_req && !i_win;
  end

  always_comb begin
    mem_en_sel    = 1'b0;
    mem_we_sel    = 1'b0;
    mem_wstrb_sel = '0;
    mem_addr_sel  = bus.i_addr;
    mem_wdata_sel = bus.d_wdata;
    owner_d       = OWN_NONE;
    if (i_win) begin
      mem_en_sel = 1'b1;
      owner_d    = OWN_I;
    end else if (d_win) begin
      mem_en_sel   = 1'b1;
      mem_we_sel   = bus.d_we;
      mem_addr_sel = bus.d_addr;
      if (bus.d_we) begin
        mem_wstrb_sel = bus.d_wstrb;
      end else begin
        owner_d = OWN_D;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign bus.i_gnt     = i_win;
  assign bus.d_gnt     = d_win;
  assign bus.mem_en    = mem_en_sel;
  assign bus.mem_we    = mem_we_sel;
  assign bus.mem_wstrb = mem_wstrb_sel;
  assign bus.mem_addr  = mem_addr_sel;
  assign bus.mem_wdata = mem_wdata_sel;

  assign bus.i_rvalid  = (owner_q == OWN_I);
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases then random traffic
// against a behavioural model of grant order, read return and memory contents.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Environment SRAM, driven purely from the DUT's mem_* pins.
  logic [31:0] sram [16];
  // Reference view of memory, driven from requester payloads.
  logic [31:0] exp_mem [16];

  int          run;
  int          pend_own;
  logic [31:0] pend_data;
  logic        last_i_gnt, last_d_gnt, last_i_rvalid, last_d_rvalid;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr[5:2]] <= merge(sram[bus.mem_addr[5:2]], bus.mem_wdata, bus.mem_wstrb);
      else            bus.mem_rdata <= sram[bus.mem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance model, retire granted requests.
  task automatic step();
    logic ei, ed;
    #3;
    ei = !rst && bus.i_req && (!bus.d_req || (GUARD && run >= int'(MAX_WAIT)));
    ed = !rst && bus.d_req && !ei;
    chk("i_gnt", bus.i_gnt, ei);
    chk("d_gnt", bus.d_gnt, ed);
    if (ei || ed) begin
      chk("mem_en", bus.mem_en, 1);
      chk("mem_addr", bus.mem_addr, ei ? bus.i_addr : bus.d_addr);
      chk("mem_we", bus.mem_we, ed && bus.d_we);
      if (ei) chk("mem_wstrb_i", bus.mem_wstrb, 0);
      if (ed && bus.d_we) begin
        chk("mem_wstrb_d", bus.mem_wstrb, bus.d_wstrb);
        chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
      end
    end else begin
      chk("idle_mem_en", bus.mem_en, 0);
      chk("idle_mem_we", bus.mem_we, 0);
      chk("idle_mem_wstrb", bus.mem_wstrb, 0);
    end
    chk("i_rvalid", bus.i_rvalid, pend_own == 1);
    chk("d_rvalid", bus.d_rvalid, pend_own == 2);
    if (pend_own == 1) chk("i_rdata", bus.i_rdata, pend_data);
    if (pend_own == 2) chk("d_rdata", bus.d_rdata, pend_data);
    last_i_gnt    = bus.i_gnt;
    last_d_gnt    = bus.d_gnt;
    last_i_rvalid = bus.i_rvalid;
    last_d_rvalid = bus.d_rvalid;

    pend_own = 0;
    if (ei) begin
      pend_own  = 1;
      pend_data = exp_mem[bus.i_addr[5:2]];
    end else if (ed) begin
      if (bus.d_we) begin
        exp_mem[bus.d_addr[5:2]] = merge(exp_mem[bus.d_addr[5:2]], bus.d_wdata, bus.d_wstrb);
      end else begin
        pend_own  = 2;
        pend_data = exp_mem[bus.d_addr[5:2]];
      end
    end
    if (rst || !bus.i_req || ei) run = 0;
    else if (run < int'(MAX_WAIT)) run = run + 1;

    @(posedge clk);
    #2;
    if (ei) bus.i_req = 1'b0;
    if (ed) bus.d_req = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      sram[k]    = $urandom;
      exp_mem[k] = sram[k];
    end
    sram[0]    = 32'h2002_0005;
    exp_mem[0] = 32'h2002_0005;
    run = 0; pend_own = 0; pend_data = '0;

    // Reset state, with requests present to confirm they are masked.
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'hF;
    bus.d_addr = 32'h8; bus.d_wdata = 32'h1234;
    #2;
    step();
    chk("rst_i_rvalid", bus.i_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    rst = 1'b0;
    step();

    // Lone fetch from 0x0.
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    step();
    chk("fetch_gnt", last_i_gnt, 1);
    step();
    chk("fetch_rvalid", last_i_rvalid, 1);
    chk("fetch_rdata", bus.i_rdata, 32'h2002_0005);
    chk("fetch_no_d_rvalid", last_d_rvalid, 0);

    // Full-word write to 0x50.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h50;
    bus.d_wdata = 32'h7; bus.d_wstrb = 4'hF;
    step();
    chk("wr_gnt", last_d_gnt, 1);
    step();
    chk("wr_no_rvalid", last_d_rvalid | last_i_rvalid, 0);

    // Simultaneous requests then fetch alone.
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
    step();
    chk("both_c0_d_gnt", last_d_gnt, 1);
    step();
    chk("both_c1_i_gnt", last_i_gnt, 1);
    chk("both_c1_d_rvalid", last_d_rvalid, 1);
    step();
    chk("both_c2_i_rvalid", last_i_rvalid, 1);

    // Starvation window: data held 8 cycles with fetch pending.
    for (int k = 0; k < 8; k++) begin
      bus.i_req = 1'b1; bus.i_addr = 32'h4;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h8;
      step();
      chk("starve_i_gnt", last_i_gnt, GUARD && k == 4);
      chk("starve_d_gnt", last_d_gnt, !(GUARD && k == 4));
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();
    step();

    // Reset pulse the cycle after a data read grant.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50;
    step();
    chk("rr_d_gnt", last_d_gnt, 1);
    rst = 1'b1;
    #1;
    chk("rr_async_drop", bus.d_rvalid, 0);
    pend_own = 0;
    step();
    rst = 1'b0;
    step();
    chk("rr_no_late_rvalid", last_d_rvalid, 0);
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    step();
    chk("rr_fetch_gnt", last_i_gnt, 1);
    step();
    chk("rr_fetch_rvalid", last_i_rvalid, 1);

    // Random traffic; requesters hold payload until granted.
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_req && $urandom_range(9, 0) < 6) begin
        bus.i_req  = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(9, 0) < 7) begin
        bus.d_req   = 1'b1;
        bus.d_we    = $urandom_range(1, 0) == 1;
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
        bus.d_wstrb = 4'($urandom);
      end
      step();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified SRAM between the core's instruction-fetch port and data port, so the single-cycle core can run against one physical memory instead of separate inst/data SRAMs. It grants one requester per cycle through a req/gnt handshake. Read data returns one cycle after the grant, steered back to the granted requester. A starvation guard keeps a data-heavy instruction stream from blocking fetch indefinitely.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; must be a multiple of 8
- MAX_WAIT, 4, consecutive denied instruction cycles before fetch takes priority; legal range 1..15

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction byte address
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_wstrb  in  DATA_W/8  byte write enables; ignored on reads
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  SRAM access this cycle
- mem_we  out  1  SRAM write
- mem_wstrb  out  DATA_W/8  SRAM byte enables
- mem_addr  out  ADDR_W  SRAM byte address, passed through unmodified
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we = 0

## Operation
- Requesters hold req and all payload stable until gnt; gnt is a one-cycle acceptance.
- Grant is combinational from req and registered state. At most one gnt per cycle.
- Default priority is data over instruction.
- Priority override: when wait_cnt == MAX_WAIT and i_req = 1, instruction wins.
- The mem_* outputs mux the granted requester's payload.
  - When nothing is granted: mem_en = 0, mem_we = 0, mem_wstrb = 0.
  - When instruction is granted: mem_we = 0 and mem_wstrb = 0.
- Owner register: {OWN_NONE, OWN_I, OWN_D}.
  - Loads the granted requester for reads, otherwise OWN_NONE.
  - Next cycle, OWN_I asserts i_rvalid and OWN_D asserts d_rvalid.
- i_rdata and d_rdata are both wired to mem_rdata. Each is meaningful only with its rvalid.
- Writes complete at grant and produce no rvalid.
- wait_cnt behaviour:
  - Increments when i_req = 1 and i_gnt = 0.
  - Clears when i_gnt = 1 or i_req = 0.
  - Saturates at MAX_WAIT.

## Timing
- Read latency: gnt in cycle N, rvalid and rdata in cycle N+1, exactly one cycle, no bubbles.
- Back-to-back grants are allowed every cycle, to either requester. Cycle N+1 may grant a new request while returning N's data.
- Reset values:
  - i_gnt, d_gnt, mem_en, mem_we, mem_wstrb = 0 while rst is high.
  - i_rvalid, d_rvalid = 0.
  - owner = OWN_NONE, wait_cnt = 0.
  - Data outputs follow mem_rdata and are don't-care.
- Reset asserted mid-read: the pending rvalid is dropped in the same cycle (asynchronous) and is not delivered after release.
- Simultaneous i_req and d_req with wait_cnt < MAX_WAIT: d granted, wait_cnt + 1.
- Simultaneous i_req and d_req with wait_cnt == MAX_WAIT: i granted, wait_cnt → 0.
- Lone request: granted in the same cycle regardless of wait_cnt.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - wait_cnt and the priority override are built as described.
- MEM_ARB_STARVE_GUARD_EN undefined:
  - No counter; data always wins and MAX_WAIT is unused.
  - Instruction fetch may starve under continuous d_req.
  - All other behaviour is identical.

## Structure
- Package mem_arb_pkg holds:
  - owner_t enum (OWN_NONE, OWN_I, OWN_D)
  - the default widths
  - WAIT_W = $clog2(MAX_WAIT+1) helper function
- One sub-module, mem_arb_starve_cnt:
  - Inputs: i_req, i_gnt.
  - Output: prio_i.
  - Instantiated only under MEM_ARB_STARVE_GUARD_EN.
- The top level holds the grant logic, payload mux, and owner register.

## Test plan
- i_req only, i_addr = 0x0, mem_rdata = 0x20020005:
  - i_gnt = 1 and mem_addr = 0x0 in cycle N.
  - i_rvalid = 1 and i_rdata = 0x20020005 in cycle N+1.
  - d_rvalid = 0 throughout.
- d write, d_addr = 0x50, d_wdata = 7, d_wstrb = 0xF:
  - d_gnt = 1, mem_we = 1, mem_wstrb = 0xF, mem_addr = 0x50 in the same cycle.
  - No rvalid the next cycle.
- i_req and d_req (read) together for one cycle, then i_req alone:
  - Cycle 0: d granted.
  - Cycle 1: i granted and d_rvalid = 1.
  - Cycle 2: i_rvalid = 1.
- Guard on, MAX_WAIT = 4, d_req held for 8 cycles, i_req held:
  - d granted in cycles 0–3, i in cycle 4, d in cycles 5–7.
- Guard off, same stimulus: d granted all 8 cycles, i_gnt never asserted.
- Reset pulse in the cycle after a d read grant:
  - d_rvalid stays 0 after reset release.
  - A fresh i_req after release is granted normally.
